// File: rtl/ph_alarm_controller.sv
// Confirms blood-pH abnormality runs, raises a latched alarm with cause code, and clears after ack plus a normal run.
// Optional PH_ALARM_HISTORY_EN builds the saturating abnormal-sample counter; otherwise abnormalCount is tied to 0.
module ph_alarm_controller #(
  parameter int CONFIRM_COUNT = 3,
  parameter int CLEAR_COUNT   = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sampleValid,
  input  logic       abnormalityP,
  input  logic       abnormalityQ,
  input  logic       alarmAck,
  output logic       alarm,
  output logic [1:0] alarmCode,
  output logic [1:0] state,
  output logic [7:0] abnormalCount
);

  // state   | meaning
  // NORMAL  | no abnormal run in progress
  // SUSPECT | abnormal run shorter than CONFIRM_COUNT
  // ALARM   | alarm raised, waiting for operator ack
  // RECOVER | acked, counting normal samples toward NORMAL
  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    SUSPECT = 2'b01,
    ALARM   = 2'b10,
    RECOVER = 2'b11
  } stateT;

  localparam logic [CNT_W-1:0] CONFIRM_C = CNT_W'(CONFIRM_COUNT);
  localparam logic [CNT_W-1:0] CLEAR_C   = CNT_W'(CLEAR_COUNT);

  stateT            curState, nextState;
  logic [CNT_W-1:0] run, runNext, clearRun, clearRunNext;
  logic [1:0]       codeNext;
  logic             abnSample, normSample;
  logic [1:0]       flags;

  assign flags      = {abnormalityQ, abnormalityP};
  assign abnSample  = sampleValid & (abnormalityP | abnormalityQ);
  assign normSample = sampleValid & ~abnormalityP & ~abnormalityQ;
  assign state      = curState;

  always_comb begin
    nextState    = curState;
    runNext      = run;
    clearRunNext = clearRun;
    codeNext     = alarmCode;
    case (curState)
      NORMAL: begin
        if (abnSample) begin
          codeNext = alarmCode | flags;
          if (CONFIRM_COUNT == 1) begin
            nextState = ALARM;
            runNext   = '0;
          end else begin
            nextState = SUSPECT;
            runNext   = CNT_W'(1);
          end
        end
      end
      SUSPECT: begin
        if (abnSample) begin
          codeNext = alarmCode | flags;
          if (run + 1'b1 == CONFIRM_C) begin
            nextState = ALARM;
            runNext   = '0;
          end else begin
            runNext = run + 1'b1;
          end
        end else if (normSample) begin
          nextState = NORMAL;
          runNext   = '0;
          codeNext  = 2'b00;
        end
      end
      ALARM: begin
        // Ack takes priority, but a coincident abnormal sample still marks the cause.
        if (abnSample) codeNext = alarmCode | flags;
        if (alarmAck) begin
          nextState    = RECOVER;
          clearRunNext = '0;
        end
      end
      RECOVER: begin
        if (abnSample) begin
          nextState    = ALARM;
          codeNext     = alarmCode | flags;
          clearRunNext = '0;
        end else if (normSample) begin
          if (clearRun + 1'b1 == CLEAR_C) begin
            nextState    = NORMAL;
            codeNext     = 2'b00;
            clearRunNext = '0;
          end else begin
            clearRunNext = clearRun + 1'b1;
          end
        end
      end
      default: nextState = NORMAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      curState  <= NORMAL;
      run       <= '0;
      clearRun  <= '0;
      alarmCode <= 2'b00;
      alarm     <= 1'b0;
    end else begin
      curState  <= nextState;
      run       <= runNext;
      clearRun  <= clearRunNext;
      alarmCode <= codeNext;
      alarm     <= (nextState == ALARM);
    end
  end

`ifdef PH_ALARM_HISTORY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      abnormalCount <= 8'd0;
    end else if (abnSample && abnormalCount != 8'hFF) begin
      abnormalCount <= abnormalCount + 8'd1;
    end
  end
`else
  assign abnormalCount = 8'd0;
`endif

endmodule

// File: tb/tb_ph_alarm_controller.sv
// Directed self-checking bench for ph_alarm_controller with CONFIRM_COUNT=3, CLEAR_COUNT=4.
// Expected abnormalCount follows PH_ALARM_HISTORY_EN the same way the design does.
module tb_ph_alarm_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sampleValid = 1'b0;
  logic       abnormalityP = 1'b0;
  logic       abnormalityQ = 1'b0;
  logic       alarmAck = 1'b0;
  logic       alarm;
  logic [1:0] alarmCode;
  logic [1:0] state;
  logic [7:0] abnormalCount;

  int checks = 0;
  int failures = 0;
  int expAbn = 0;

  ph_alarm_controller #(
    .CONFIRM_COUNT(3),
    .CLEAR_COUNT(4),
    .CNT_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sampleValid(sampleValid),
    .abnormalityP(abnormalityP),
    .abnormalityQ(abnormalityQ),
    .alarmAck(alarmAck),
    .alarm(alarm),
    .alarmCode(alarmCode),
    .state(state),
    .abnormalCount(abnormalCount)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] expCnt();
`ifdef PH_ALARM_HISTORY_EN
    return (expAbn > 255) ? 8'd255 : 8'(expAbn);
`else
    return 8'd0;
`endif
  endfunction

  // Drive one edge's inputs, then release them just after the edge.
  task automatic step(input logic v, input logic p, input logic q, input logic ack);
    @(negedge clock);
    sampleValid = v; abnormalityP = p; abnormalityQ = q; alarmAck = ack;
    @(posedge clock);
    #1;
    if (v && (p || q)) expAbn++;
    sampleValid = 0; abnormalityP = 0; abnormalityQ = 0; alarmAck = 0;
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1;
    expAbn = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    #1;
    checks++;
    if ({alarm, alarmCode, state, abnormalCount} !== 13'b0) begin
      failures++;
      $display("FAIL reset got alarm=%b code=%b state=%b cnt=%0d want all 0", alarm, alarmCode, state, abnormalCount);
    end
  endtask

  task automatic test_confirm();
    logic [4:0] expS [3] = '{5'b0_01_01, 5'b0_01_01, 5'b1_01_10};
    applyReset();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      checks++;
      if ({alarm, alarmCode, state, abnormalCount} !== {expS[i], expCnt()}) begin
        failures++;
        $display("FAIL confirm[%0d] got a/code/st=%b cnt=%0d want %b cnt=%0d", i, {alarm, alarmCode, state}, abnormalCount, expS[i], expCnt());
      end
    end
  endtask

  task automatic test_suspect_drop();
    logic [1:0] stim [4] = '{2'b10, 2'b10, 2'b00, 2'b01};
    logic [4:0] expS [4] = '{5'b0_10_01, 5'b0_10_01, 5'b0_00_00, 5'b0_01_01};
    applyReset();
    for (int i = 0; i < 4; i++) begin
      step(1, stim[i][0], stim[i][1], 0);
      checks++;
      if ({alarm, alarmCode, state, abnormalCount} !== {expS[i], expCnt()}) begin
        failures++;
        $display("FAIL suspect_drop[%0d] got a/code/st=%b cnt=%0d want %b cnt=%0d", i, {alarm, alarmCode, state}, abnormalCount, expS[i], expCnt());
      end
    end
  endtask

  task automatic test_ack_with_abnormal();
    logic [3:0] stim [5] = '{4'b1011, 4'b1000, 4'b1000, 4'b1000, 4'b1000}; // {valid,p,q,ack}
    logic [4:0] expS [5] = '{5'b0_11_11, 5'b0_11_11, 5'b0_11_11, 5'b0_11_11, 5'b0_00_00};
    applyReset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
      checks++;
      if ({alarm, alarmCode, state, abnormalCount} !== {expS[i], expCnt()}) begin
        failures++;
        $display("FAIL ack_abn[%0d] got a/code/st=%b cnt=%0d want %b cnt=%0d", i, {alarm, alarmCode, state}, abnormalCount, expS[i], expCnt());
      end
    end
  endtask

  task automatic test_recover_rearm();
    logic [3:0] stim [11] = '{4'b0001, 4'b1000, 4'b1000, 4'b1100, 4'b1000, 4'b0001,
                              4'b1000, 4'b1000, 4'b0001, 4'b1000, 4'b1000};
    logic [4:0] expS [11] = '{5'b0_01_11, 5'b0_01_11, 5'b0_01_11, 5'b1_01_10, 5'b1_01_10, 5'b0_01_11,
                              5'b0_01_11, 5'b0_01_11, 5'b0_01_11, 5'b0_01_11, 5'b0_00_00};
    applyReset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    // Index 8 is an ack in RECOVER, which must not disturb the clear run.
    for (int i = 0; i < 11; i++) begin
      step(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
      checks++;
      if ({alarm, alarmCode, state, abnormalCount} !== {expS[i], expCnt()}) begin
        failures++;
        $display("FAIL recover[%0d] got a/code/st=%b cnt=%0d want %b cnt=%0d", i, {alarm, alarmCode, state}, abnormalCount, expS[i], expCnt());
      end
    end
  endtask

  task automatic test_saturation();
    applyReset();
    for (int i = 0; i < 300; i++) begin
      step(1, 1, 0, 0);
      if (i == 254 || i == 299) begin
        checks++;
        if ({alarm, alarmCode, state, abnormalCount} !== {5'b1_01_10, expCnt()}) begin
          failures++;
          $display("FAIL saturation[%0d] got a/code/st=%b cnt=%0d want 10110 cnt=%0d", i, {alarm, alarmCode, state}, abnormalCount, expCnt());
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] stim [4] = '{4'b0001, 4'b1001, 4'b0110, 4'b0001};
    applyReset();
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
    @(negedge clock);
    #2 reset = 1'b1;
    expAbn = 0;
    #1;
    checks++;
    if ({alarm, alarmCode, state, abnormalCount} !== 13'b0) begin
      failures++;
      $display("FAIL async_reset got alarm=%b code=%b state=%b cnt=%0d want all 0", alarm, alarmCode, state, abnormalCount);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
      checks++;
      if ({alarm, alarmCode, state, abnormalCount} !== 13'b0) begin
        failures++;
        $display("FAIL idle_ack[%0d] got a/code/st=%b cnt=%0d want 00000 cnt=0", i, {alarm, alarmCode, state}, abnormalCount);
      end
    end
  endtask

  initial begin
    test_reset();
    test_confirm();
    test_suspect_drop();
    test_ack_with_abnormal();
    test_recover_rearm();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
